// File: rtl/darkriscv_wb_mailbox.sv
// Wishbone classic register window with host<->core 32-bit mailbox FIFOs.
// Latency: ack and read data registered one cycle after a strobe hit; FIFO heads fall through.
// Backpressure: H2C valid/ready and C2H ready = ~full; host overflow/underflow are dropped and flagged in ERR.
//
// Ports:
//   wb_clk_i, wb_rst_n          clock, async active-low reset
//   wbs_*                       Wishbone classic responder (stb/cyc/we/sel/adr/dat_i, ack/dat_o)
//   core_rst_o                  CTRL.core_rst, holds the darksocv core in reset
//   h2c_data_o/valid_o/ready_i  host-to-core FIFO head, popped on valid & ready
//   c2h_data_i/valid_i/ready_o  core-to-host FIFO push side
//   irq_o                       CTRL.irq_en & C2H not empty

// Small first-word-fall-through FIFO with occupancy count.
// Latency: push visible on the head one cycle later; pop takes effect at the clock edge.
// Backpressure: push is accepted when not full, or when full with a same-edge pop.
module darkriscv_wb_mailbox_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [3:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [3:0]    r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == 4'(DEPTH));
  assign o_empty   = (r_count == 4'd0);
  assign w_pop_ok  = i_pop & ~o_empty;
  // A push into a full FIFO succeeds only if the head leaves on the same edge.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed after being written.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

module darkriscv_wb_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        core_rst_o,
  output logic [31:0] h2c_data_o,
  output logic        h2c_valid_o,
  input  logic        h2c_ready_i,
  input  logic [31:0] c2h_data_i,
  input  logic        c2h_valid_i,
  output logic        c2h_ready_o,
  output logic        irq_o
);
  localparam logic [5:0] OFF_CTRL    = 6'h00;
  localparam logic [5:0] OFF_STATUS  = 6'h01;
  localparam logic [5:0] OFF_H2C     = 6'h02;
  localparam logic [5:0] OFF_C2H     = 6'h03;
  localparam logic [5:0] OFF_SCRATCH = 6'h04;
  localparam logic [5:0] OFF_ERR     = 6'h05;

  logic        r_ack;
  logic [31:0] r_dat;
  logic [1:0]  r_ctrl;     // [0] core_rst, [1] irq_en
  logic [31:0] r_scratch;
  logic [1:0]  r_err;      // [0] ovf, [1] unf

  logic        w_hit, w_wr, w_rd;
  logic [5:0]  w_off;
  logic        w_h2c_push, w_h2c_pop;
  logic        w_c2h_push, w_c2h_rd, w_c2h_pop;
  logic        w_ovf_set, w_unf_set;
  logic [1:0]  w_err_clr;
  logic [31:0] w_rdata;

  logic [31:0] w_h2c_head, w_c2h_head;
  logic [3:0]  w_h2c_count, w_c2h_count;
  logic        w_h2c_full, w_h2c_empty, w_c2h_full, w_c2h_empty;

  // Byte lanes are implied by sel; the low address bits carry no information.
  logic w_unused;
  assign w_unused = &{1'b0, wbs_adr_i[1:0]};

  // ~r_ack makes the cycle after an ack dead, so a held strobe is acked every other cycle.
  assign w_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~r_ack;
  assign w_off = wbs_adr_i[7:2];
  assign w_wr  = w_hit & wbs_we_i;
  assign w_rd  = w_hit & ~wbs_we_i;

  assign w_h2c_push = w_wr & (w_off == OFF_H2C);
  assign w_h2c_pop  = h2c_ready_i & ~w_h2c_empty;
  assign w_c2h_push = c2h_valid_i & ~w_c2h_full;
  assign w_c2h_rd   = w_rd & (w_off == OFF_C2H);
  // Emptiness is the registered state, so a same-edge core push cannot rescue an empty read.
  assign w_c2h_pop  = w_c2h_rd & ~w_c2h_empty;

  assign w_ovf_set = w_h2c_push & w_h2c_full & ~w_h2c_pop;
  assign w_unf_set = w_c2h_rd & w_c2h_empty;
  assign w_err_clr = (w_wr && (w_off == OFF_ERR) && wbs_sel_i[0]) ? wbs_dat_i[1:0] : 2'b00;

  darkriscv_wb_mailbox_fifo #(.W(32), .DEPTH(DEPTH)) u_h2c (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n),
    .i_push  (w_h2c_push),
    .i_dat   (wbs_dat_i),
    .i_pop   (w_h2c_pop),
    .o_head  (w_h2c_head),
    .o_count (w_h2c_count),
    .o_full  (w_h2c_full),
    .o_empty (w_h2c_empty)
  );

  darkriscv_wb_mailbox_fifo #(.W(32), .DEPTH(DEPTH)) u_c2h (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n),
    .i_push  (w_c2h_push),
    .i_dat   (c2h_data_i),
    .i_pop   (w_c2h_pop),
    .o_head  (w_c2h_head),
    .o_count (w_c2h_count),
    .o_full  (w_c2h_full),
    .o_empty (w_c2h_empty)
  );

  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      OFF_CTRL:    w_rdata[1:0]  = r_ctrl;
      OFF_STATUS:  w_rdata[15:0] = {w_c2h_count, w_h2c_count, 4'h0,
                                    w_c2h_empty, w_c2h_full, w_h2c_empty, w_h2c_full};
      OFF_C2H:     w_rdata       = w_c2h_empty ? 32'h0 : w_c2h_head;
      OFF_SCRATCH: w_rdata       = r_scratch;
      OFF_ERR:     w_rdata[1:0]  = r_err;
      default:     w_rdata       = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ack     <= 1'b0;
      r_dat     <= 32'h0;
      r_ctrl    <= 2'b01;
      r_scratch <= 32'h0;
      r_err     <= 2'b00;
    end else begin
      r_ack <= w_hit;
      r_dat <= w_rd ? w_rdata : 32'h0;
      if (w_wr && (w_off == OFF_CTRL) && wbs_sel_i[0]) r_ctrl <= wbs_dat_i[1:0];
      for (int b = 0; b < 4; b++) begin
        if (w_wr && (w_off == OFF_SCRATCH) && wbs_sel_i[b])
          r_scratch[8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
      // Set after clear: a new event on the clearing edge is not lost.
      r_err <= (r_err & ~w_err_clr) | {w_unf_set, w_ovf_set};
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign core_rst_o  = r_ctrl[0];
  assign irq_o       = r_ctrl[1] & ~w_c2h_empty;
  assign h2c_data_o  = w_h2c_head;
  assign h2c_valid_o = ~w_h2c_empty;
  assign c2h_ready_o = ~w_c2h_full;
endmodule

// File: tb/tb_darkriscv_wb_mailbox.sv
// Scoreboard bench for darkriscv_wb_mailbox: directed Wishbone and core-side vectors,
// expected responses queued at issue time and checked by a negedge monitor.
module tb_darkriscv_wb_mailbox;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dati = 32'h0;
  logic        ack;
  logic [31:0] dato;
  logic        core_rst;
  logic [31:0] h2c_data;
  logic        h2c_valid;
  logic        h2c_ready = 1'b0;
  logic [31:0] c2h_data = 32'h0;
  logic        c2h_valid = 1'b0;
  logic        c2h_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] wb_q[$];
  logic [31:0] h2c_q[$];

  darkriscv_wb_mailbox #(.BASE_ADDR(BASE), .DEPTH(4)) dut (
    .wb_clk_i    (clk),
    .wb_rst_n    (rst_n),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (dati),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (dato),
    .core_rst_o  (core_rst),
    .h2c_data_o  (h2c_data),
    .h2c_valid_o (h2c_valid),
    .h2c_ready_i (h2c_ready),
    .c2h_data_i  (c2h_data),
    .c2h_valid_i (c2h_valid),
    .c2h_ready_o (c2h_ready),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compares every acked response and every core-side H2C pop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) begin
        checks++;
        if (wb_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected_ack got dat 0x%08h expected no ack", dato);
        end else begin
          logic [31:0] e;
          e = wb_q.pop_front();
          if (dato !== e) begin
            errors++;
            $display("FAIL wb_rdata got 0x%08h expected 0x%08h", dato, e);
          end
        end
      end
      if (h2c_valid && h2c_ready) begin
        checks++;
        if (h2c_q.size() == 0) begin
          errors++;
          $display("FAIL h2c_unexpected_pop got 0x%08h expected none", h2c_data);
        end else begin
          logic [31:0] e;
          e = h2c_q.pop_front();
          if (h2c_data !== e) begin
            errors++;
            $display("FAIL h2c_data got 0x%08h expected 0x%08h", h2c_data, e);
          end
        end
      end
    end
  end

  // One Wishbone access; the expected read data (0 for writes) goes to the scoreboard.
  task automatic wb(input logic w, input logic [31:0] off, input logic [31:0] d,
                    input logic [3:0] s, input logic [31:0] exp);
    int n;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE + off; dati = d; sel = s;
    wb_q.push_back(exp);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 20);
    chk("ack_latency", n, 1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'b0, ack}, 32'h0);
    chk("dat_idle_zero", dato, 32'h0);
  endtask

  task automatic drain_h2c();
    int n;
    @(posedge clk); #1;
    h2c_ready = 1'b1;
    n = 0;
    while (h2c_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    h2c_ready = 1'b0;
    chk("h2c_drained", {31'b0, h2c_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acks;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dat", dato, 32'h0);
    chk("rst_core_rst", {31'b0, core_rst}, 32'h1);
    chk("rst_h2c_valid", {31'b0, h2c_valid}, 32'h0);
    chk("rst_c2h_ready", {31'b0, c2h_ready}, 32'h1);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    wb(1'b0, 32'h04, 0, 4'hF, 32'h0000_000A);
    wb(1'b0, 32'h00, 0, 4'hF, 32'h0000_0001);

    // CTRL write, then an out-of-window access that must never be acked
    wb(1'b1, 32'h00, 32'h2, 4'h1, 32'h0);
    chk("ctrl_core_rst", {31'b0, core_rst}, 32'h0);
    chk("ctrl_irq_idle", {31'b0, irq}, 32'h0);
    wb(1'b0, 32'h00, 0, 4'hF, 32'h0000_0002);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3100_0000;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("outside_window_acks", acks, 0);

    // SCRATCH byte enables
    wb(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0);
    wb(1'b1, 32'h10, 32'h1122_3344, 4'h5, 32'h0);
    wb(1'b0, 32'h10, 0, 4'hF, 32'hDE22_BE44);

    // H2C overflow: five pushes, core not ready
    for (int i = 1; i <= 5; i++) wb(1'b1, 32'h08, i, 4'h0, 32'h0);
    chk("h2c_valid_full", {31'b0, h2c_valid}, 32'h1);
    wb(1'b0, 32'h04, 0, 4'hF, 32'h0000_0409);
    wb(1'b0, 32'h14, 0, 4'hF, 32'h0000_0001);
    wb(1'b0, 32'h08, 0, 4'hF, 32'h0000_0000);
    for (int i = 1; i <= 4; i++) h2c_q.push_back(i);
    drain_h2c();
    wb(1'b1, 32'h14, 32'h1, 4'h1, 32'h0);
    wb(1'b0, 32'h14, 0, 4'hF, 32'h0000_0000);

    // C2H: two core pushes, host pops, then underflow
    @(posedge clk); #1;
    c2h_valid = 1'b1; c2h_data = 32'hA5;
    @(posedge clk); #1;
    c2h_data = 32'h5A;
    @(posedge clk); #1;
    c2h_valid = 1'b0;
    chk("c2h_irq_set", {31'b0, irq}, 32'h1);
    wb(1'b0, 32'h04, 0, 4'hF, 32'h0000_2002);
    wb(1'b0, 32'h0C, 0, 4'hF, 32'h0000_00A5);
    chk("c2h_irq_one_left", {31'b0, irq}, 32'h1);
    wb(1'b0, 32'h0C, 0, 4'hF, 32'h0000_005A);
    chk("c2h_irq_clear", {31'b0, irq}, 32'h0);
    wb(1'b0, 32'h0C, 0, 4'hF, 32'h0000_0000);
    wb(1'b0, 32'h14, 0, 4'hF, 32'h0000_0002);
    wb(1'b1, 32'h14, 32'h2, 4'h1, 32'h0);

    // Full H2C: host push and core pop on the same edge
    for (int i = 10; i <= 13; i++) wb(1'b1, 32'h08, i, 4'hF, 32'h0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h08; dati = 32'd14; sel = 4'hF;
    h2c_ready = 1'b1;
    wb_q.push_back(32'h0);
    h2c_q.push_back(32'd10);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; h2c_ready = 1'b0;
    chk("pushpop_ack", {31'b0, ack}, 32'h1);
    wb(1'b0, 32'h04, 0, 4'hF, 32'h0000_0409);
    wb(1'b0, 32'h14, 0, 4'hF, 32'h0000_0000);
    for (int i = 11; i <= 14; i++) h2c_q.push_back(i);
    drain_h2c();

    // Reset asserted while a strobe is being acked
    wb(1'b1, 32'h08, 32'h77, 4'hF, 32'h0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h04;
    @(posedge clk); #1;
    chk("midrst_ack_before", {31'b0, ack}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack_after", {31'b0, ack}, 32'h0);
    chk("midrst_dat", dato, 32'h0);
    chk("midrst_h2c_valid", {31'b0, h2c_valid}, 32'h0);
    chk("midrst_c2h_ready", {31'b0, c2h_ready}, 32'h1);
    chk("midrst_core_rst", {31'b0, core_rst}, 32'h1);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wb(1'b0, 32'h04, 0, 4'hF, 32'h0000_000A);
    wb(1'b0, 32'h10, 0, 4'hF, 32'h0000_0000);

    repeat (2) @(posedge clk);
    chk("wb_queue_empty", wb_q.size(), 0);
    chk("h2c_queue_empty", h2c_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/darkriscv_wb_mailbox.md
Name: darkriscv_wb_mailbox

Overview:
- Wishbone classic responder behind the management SoC initiator: drives `wbs_ack_o` / `wbs_dat_o` for a small register window.
- Gives the host a control register (darksocv core reset, irq enable) and a scratch register.
- Provides two 32-bit mailbox FIFOs with valid/ready core-side ports: host-to-core (H2C) and core-to-host (C2H).
- Sits in `user_project_wrapper` between the Wishbone slave pins and the darksocv core.

Parameters:
- `BASE_ADDR`, `32'h3000_0000`: window base; decode compares `wbs_adr_i[31:8]` with `BASE_ADDR[31:8]`.
- `DEPTH`, `4`: entries per FIFO; power of 2, range 2..8.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_n`  in  1  asynchronous active-low reset.
- `wbs_stb_i`  in  1  Wishbone strobe.
- `wbs_cyc_i`  in  1  Wishbone cycle.
- `wbs_we_i`  in  1  write enable.
- `wbs_sel_i`  in  4  byte selects.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  acknowledge.
- `wbs_dat_o`  out  32  read data.
- `core_rst_o`  out  1  active-high hold-reset to darksocv (CTRL bit0).
- `h2c_data_o`  out  32  head of H2C FIFO.
- `h2c_valid_o`  out  1  H2C not empty.
- `h2c_ready_i`  in  1  core pops H2C when valid & ready.
- `c2h_data_i`  in  32  core write data.
- `c2h_valid_i`  in  1  core push request.
- `c2h_ready_o`  out  1  C2H not full.
- `irq_o`  out  1  `CTRL.irq_en & ~c2h_empty` (registered-state based, no input combinational path).

Behaviour:
- Reset (async assert, sync release):
  - `wbs_ack_o=0`, `wbs_dat_o=0`.
  - CTRL=0x1, so `core_rst_o=1` and `irq_o=0`.
  - SCRATCH=0, ERR=0.
  - Both FIFOs empty, so `h2c_valid_o=0` and `c2h_ready_o=1`.
  - Reset mid-transaction drops ack immediately; the pending access has no side effect.
- Selection: `hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8]==BASE_ADDR[31:8]) & ~wbs_ack_o`.
  - Accesses outside the window are never acked; they belong to other responders.
- Ack timing:
  - `hit` at edge N raises `wbs_ack_o` for exactly one cycle after edge N.
  - `wbs_dat_o` is registered at edge N. Single-cycle latency.
  - All register side effects occur at edge N.
  - The ack is forced low on the following cycle, so back-to-back strobes are acked every other cycle.
  - `wbs_dat_o` returns to 0 when ack drops; write cycles return 0.
- Register map (offset = `adr[7:2]`×4):
  - 0x00 CTRL, rw: bit0 `core_rst`, bit1 `irq_en`. Written only if `sel[0]`.
  - 0x04 STATUS, ro:
    - bit0 h2c_full, bit1 h2c_empty, bit2 c2h_full, bit3 c2h_empty.
    - [11:8] h2c_count, [15:12] c2h_count. Upper bits 0.
  - 0x08 H2C_DATA, wo: write pushes full 32-bit `wbs_dat_i`; `sel` ignored. Read returns 0.
  - 0x0C C2H_DATA, ro: read pops and returns the head. Writes are ignored.
  - 0x10 SCRATCH, rw: per-byte `sel` honoured.
  - 0x14 ERR, rw1c: bit0 `ovf`, bit1 `unf`. Cleared by writing 1 with `sel[0]`.
  - All other in-window offsets are acked, read 0, and ignore writes.
- FIFOs:
  - Circular pointers of log2(DEPTH) bits with wrap-around; separate count register 0..DEPTH.
  - First-word-fall-through: data port shows the head entry.
- H2C boundary rules:
  - Push when full, with no same-edge core pop: data dropped, `ERR.ovf` set, count unchanged.
  - Push when full, with same-edge core pop: accepted, count unchanged.
  - Push and pop on a non-empty, non-full FIFO: both occur, count unchanged.
  - Pop when empty is impossible, since valid=0.
- C2H boundary rules:
  - `c2h_ready_o = ~c2h_full`; it does not look ahead to a same-cycle host pop.
  - Host read when empty returns 0 and sets `ERR.unf`. Emptiness is judged before a same-edge core push.
  - Simultaneous core push and host pop on a non-empty FIFO: both occur.
- ERR set vs clear on the same edge: set wins.

Test Plan:
- Reset → `ack=0`, `core_rst_o=1`, `h2c_valid_o=0`, `c2h_ready_o=1`. Read 0x04 → `0x0000_000A`. Read 0x00 → `0x1`.
- Write CTRL=0x2 (sel=0x1) → `core_rst_o=0`, `irq_en=1`. Ack is high for exactly one cycle, one cycle after stb. Read outside the window (0x3100_0000) → no ack for 10 cycles.
- SCRATCH: write `0xDEADBEEF` sel=0xF, then `0x11223344` sel=0x5 → read returns `0xDE22BE44`.
- H2C: push 5 words 1..5 with core ready=0 → STATUS h2c_count=4, h2c_full=1, ERR=0x1. Core pops in order and sees 1,2,3,4; the 5 is lost. Write ERR=0x1 → ERR reads 0.
- C2H: core pushes `0xA5`, then `0x5A` → `irq_o=1`. Reads return `0xA5`, then `0x5A`; `irq_o` falls after the second pop. A third read returns 0 and sets ERR=0x2.
- Full H2C with host push and core pop on the same edge → count stays 4, no ovf. Assert `wb_rst_n` low mid-strobe → ack clears asynchronously and FIFOs empty.
